// File: rtl/uart_pdm_pkg.sv
// Shared definitions for the UART-to-PDM loader: receiver state encodings,
// the default level-set command value and a command-match helper.
package uart_pdm_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } rx_state_e;

  localparam logic [2:0] CMD_DEFAULT = 3'b010;
  localparam logic [2:0] DATA_LAST   = 3'd7;

  function automatic logic is_cmd(input logic [7:0] frame_byte, input logic [2:0] cmd);
    return (frame_byte[7:5] == cmd);
  endfunction

endpackage

// File: rtl/uart_pdm_loader_rx_sync2.sv
// Two-flop synchroniser for an asynchronous input, with a configurable
// reset value so an idle-high line does not look like activity after reset.
module rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_r;

  // shift the async input through two flops
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {2{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[0], d};
    end
  end

  assign q = sync_r[1];

endmodule

// File: rtl/uart_pdm_loader.sv
// 8N1 UART receiver that turns level-set command bytes into a PDM level
// and a one-cycle load strobe for the downstream modulator.
module uart_pdm_loader
  import uart_pdm_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         LEVEL_W      = 5,
  parameter logic [2:0] CMD          = CMD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [LEVEL_W-1:0] level_out,
  output logic               write_en,
  output logic               frame_err,
  output logic               busy
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic               rx_s;
  rx_state_e          state_r;
  rx_state_e          state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         shift_r;
  logic               stop_done_r;
  logic               stop_bit_r;
  logic [LEVEL_W-1:0] level_r;
  logic               write_en_r;
  logic               frame_err_r;
  logic               busy_r;
  logic               cnt_tc_s;
  logic               frame_ok_s;
  logic               frame_bad_s;
  logic               load_s;
  logic               busy_s;

  rx_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // START waits half a bit to land in the middle of the start bit
  assign cnt_tc_s = (state_r == START) ? (cnt_r == HALF_TC) : (cnt_r == FULL_TC);

  // The stop sample is registered first; the frame is resolved one cycle later
  assign frame_ok_s  = (state_r == STOP) && stop_done_r && stop_bit_r;
  assign frame_bad_s = (state_r == STOP) && stop_done_r && !stop_bit_r;
  assign load_s      = frame_ok_s && is_cmd(shift_r, CMD);
  assign busy_s      = (state_s == START) || (state_s == DATA) || (state_s == STOP);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_s) state_s = START;
        else       state_s = IDLE;
      end
      START: begin
        if (cnt_tc_s) state_s = rx_s ? IDLE : DATA;
        else          state_s = START;
      end
      DATA: begin
        if (cnt_tc_s && (bit_cnt_r == DATA_LAST)) state_s = STOP;
        else                                      state_s = DATA;
      end
      STOP: begin
        if (stop_done_r) state_s = stop_bit_r ? IDLE : BREAK;
        else             state_s = STOP;
      end
      BREAK: begin
        if (rx_s) state_s = IDLE;
        else      state_s = BREAK;
      end
      default: state_s = IDLE;
    endcase
  end

  // baud counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_s != state_r) || (state_r == IDLE) || (state_r == BREAK) || cnt_tc_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // data bit counter and LSB-first shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
    end else if ((state_r == DATA) && cnt_tc_s) begin
      bit_cnt_r <= (bit_cnt_r == DATA_LAST) ? 3'd0 : bit_cnt_r + 3'd1;
      shift_r   <= {rx_s, shift_r[7:1]};
    end else if (state_r == IDLE) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= shift_r;
    end else begin
      bit_cnt_r <= bit_cnt_r;
      shift_r   <= shift_r;
    end
  end

  // stop-bit capture
  always_ff @(posedge clk) begin
    if (reset) begin
      stop_done_r <= 1'b0;
      stop_bit_r  <= 1'b1;
    end else if ((state_r == STOP) && !stop_done_r && cnt_tc_s) begin
      stop_done_r <= 1'b1;
      stop_bit_r  <= rx_s;
    end else begin
      stop_done_r <= 1'b0;
      stop_bit_r  <= stop_bit_r;
    end
  end

  // output register
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r     <= {LEVEL_W{1'b0}};
      write_en_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      level_r     <= load_s ? shift_r[LEVEL_W-1:0] : level_r;
      write_en_r  <= load_s;
      frame_err_r <= frame_bad_s;
      busy_r      <= busy_s;
    end
  end

  assign level_out = level_r;
  assign write_en  = write_en_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_pdm_loader.sv
// Self-checking bench for uart_pdm_loader: directed UART scenarios followed
// by random frames, all compared against a byte-level reference model.
module tb_uart_pdm_loader;

  localparam int CPB     = 16;
  localparam int LATENCY = 2 + 1 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [4:0] level_out;
  logic       write_en;
  logic       frame_err;
  logic       busy;

  uart_pdm_loader #(
    .CLKS_PER_BIT (CPB),
    .LEVEL_W      (5),
    .CMD          (3'b010)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .level_out (level_out),
    .write_en  (write_en),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         we_cnt = 0;
  int         fe_cnt = 0;
  int         busy_hi = 0;
  int         last_we_cyc = 0;
  logic [4:0] lv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // observe DUT outputs on the falling edge
  always @(negedge clk) begin
    if (write_en) begin
      we_cnt      <= we_cnt + 1;
      last_we_cyc <= cyc;
      lv_q.push_back(level_out);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (busy) busy_hi <= busy_hi + 1;
  end

  int         n_total = 0;
  int         n_pass = 0;
  int         start_cyc = 0;
  int         exp_we = 0;
  int         exp_fe = 0;
  logic [4:0] exp_level = 5'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // caller is at a falling edge; the frame occupies exactly 9*CPB + stop_len cycles
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    rx = 1'b0;
    start_cyc = cyc;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(stop_len);
    rx = 1'b1;
  endtask

  // reference: good frame with command bits 010 loads the low 5 bits
  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit) begin
      exp_fe++;
    end else if (b[7:5] == 3'b010) begin
      exp_we++;
      exp_level = b[4:0];
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_we_count"}, 32'(we_cnt), 32'(exp_we));
    check({tag, "_fe_count"}, 32'(fe_cnt), 32'(exp_fe));
    check({tag, "_level"}, 32'(level_out), 32'(exp_level));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_level"}, 32'(level_out), 32'd0);
    check({tag, "_write_en"}, 32'(write_en), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic       stop_bit;
    int         busy0;

    rx    = 1'b1;
    reset = 1'b1;
    idle(4);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(4);

    // single command byte, with latency
    send_frame(8'h48, 1'b1, CPB);
    model_frame(8'h48, 1'b1);
    idle(4);
    check("latency_0x48", 32'(last_we_cyc - start_cyc), 32'(LATENCY));
    check("level_0x48", 32'(level_out), 32'h08);
    check_model("first");

    // back-to-back frames
    lv_q.delete();
    send_frame(8'h5A, 1'b1, CPB);
    model_frame(8'h5A, 1'b1);
    send_frame(8'h4F, 1'b1, CPB);
    model_frame(8'h4F, 1'b1);
    idle(4);
    check("b2b_pulses", 32'(lv_q.size()), 32'd2);
    if (lv_q.size() == 2) begin
      check("b2b_level0", 32'(lv_q[0]), 32'h1A);
      check("b2b_level1", 32'(lv_q[1]), 32'h0F);
    end
    check_model("b2b");

    // wrong command value is dropped
    send_frame(8'h2F, 1'b1, CPB);
    model_frame(8'h2F, 1'b1);
    idle(4);
    check("wrongcmd_level", 32'(level_out), 32'h0F);
    check_model("wrongcmd");

    // bad stop bit with line held low: exactly one frame error
    send_frame(8'h44, 1'b0, 40 * CPB);
    model_frame(8'h44, 1'b0);
    idle(2 * CPB);
    check_model("break");
    send_frame(8'h44, 1'b1, CPB);
    model_frame(8'h44, 1'b1);
    idle(4);
    check("after_break_level", 32'(level_out), 32'h04);
    check_model("after_break");

    // short glitch: busy for half a bit, nothing else
    busy0 = busy_hi;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(2 * CPB);
    check("glitch_busy_cycles", 32'(busy_hi - busy0), 32'(CPB / 2));
    check("glitch_busy_end", 32'(busy), 32'd0);
    check_model("glitch");

    // reset in the middle of bit 3 of 0x5A
    b  = 8'h5A;
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = b[3];
    idle(CPB / 2);
    reset = 1'b1;
    rx    = 1'b1;
    idle(2);
    check_outputs_zero("midreset");
    reset = 1'b0;
    exp_level = 5'd0;
    idle(20 * CPB);
    check_model("midreset_quiet");
    send_frame(8'h48, 1'b1, CPB);
    model_frame(8'h48, 1'b1);
    idle(4);
    check("after_reset_level", 32'(level_out), 32'h08);
    check_model("after_reset");

    // random frames, good frames sent back to back
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      if ($urandom_range(1, 0) == 1) b[7:5] = 3'b010;
      stop_bit = ($urandom_range(3, 0) != 0);
      send_frame(b, stop_bit, CPB);
      model_frame(b, stop_bit);
      check_model($sformatf("rand%0d", n));
      if (!stop_bit) idle(2 * CPB);
    end

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
